// File: rtl/lii_kernel_wrapper.sv
// LII <-> HLS kernel adapter: splits LII beats into per-lane input FIFOs and packs
// per-lane kernel results into one registered LII beat, with a back-pressure clock enable.
module lii_kernel_wrapper #(
    parameter int          NIN    = 3,
    parameter int          NOUT   = 1,
    parameter int          W      = 8,
    parameter int          PW     = 64,
    parameter int          DEPTH  = 4,
    parameter logic [7:0]  MY_ID  = 8'h00,
    parameter logic [7:0]  DST_ID = 8'h00
) (
    input  logic                aclk,
    input  logic                arstn,
    input  logic [PW-1:0]       lii_in_tdata,
    input  logic                lii_in_tvalid,
    output logic                lii_in_tready,
    input  logic [7:0]          lii_in_src,
    input  logic [7:0]          lii_in_dst,
    output logic [PW-1:0]       lii_out_tdata,
    output logic                lii_out_tvalid,
    input  logic                lii_out_tready,
    output logic [7:0]          lii_out_src,
    output logic [7:0]          lii_out_dst,
    output logic [NIN*W-1:0]    k_in_tdata,
    output logic [NIN-1:0]      k_in_tvalid,
    input  logic [NIN-1:0]      k_in_tready,
    input  logic [NOUT*W-1:0]   k_out_tdata,
    input  logic [NOUT-1:0]     k_out_tvalid,
    output logic [NOUT-1:0]     k_out_tready,
    output logic                ce,
    output logic [15:0]         drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [NIN-1:0]    w_full;
    logic [NIN-1:0]    w_pop;
    logic              w_accept;
    logic              w_push;
    logic              w_drop;
    logic [15:0]       r_drop_cnt;
    logic              w_unused;

    // Source ID and any beat bits above the used lanes carry no meaning here.
    assign w_unused = ^{lii_in_src, lii_in_tdata};

    assign lii_in_tready = ~|w_full;
    assign w_accept      = lii_in_tvalid & lii_in_tready;
    assign w_push        = w_accept & (lii_in_dst == MY_ID);
    assign w_drop        = w_accept & (lii_in_dst != MY_ID);

    genvar gi;
    generate
        for (gi = 0; gi < NIN; gi++) begin : g_in_lane
            logic [W-1:0]  r_mem [DEPTH];
            logic [AW-1:0] r_wr_ptr;
            logic [AW-1:0] r_rd_ptr;
            logic [CW-1:0] r_cnt;
            logic          w_empty;

            assign w_empty                = (r_cnt == '0);
            assign w_full[gi]             = (r_cnt == CW'(DEPTH));
            assign w_pop[gi]              = !w_empty & k_in_tready[gi];
            assign k_in_tvalid[gi]        = !w_empty;
            assign k_in_tdata[gi*W +: W]  = r_mem[r_rd_ptr];

            always_ff @(posedge aclk) begin
                if (w_push) begin
                    r_mem[r_wr_ptr] <= lii_in_tdata[gi*W +: W];
                end
            end

            // Full is judged on the registered count, so a same-cycle pop never makes room.
            always_ff @(posedge aclk or negedge arstn) begin
                if (!arstn) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_cnt    <= '0;
                end else begin
                    if (w_push) begin
                        r_wr_ptr <= r_wr_ptr + AW'(1);
                    end
                    if (w_pop[gi]) begin
                        r_rd_ptr <= r_rd_ptr + AW'(1);
                    end
                    case ({w_push, w_pop[gi]})
                        2'b10:   r_cnt <= r_cnt + CW'(1);
                        2'b01:   r_cnt <= r_cnt - CW'(1);
                        default: r_cnt <= r_cnt;
                    endcase
                end
            end
        end
    endgenerate

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;

    logic [NOUT-1:0]   r_held;
    logic [NOUT-1:0]   w_capture;
    logic [NOUT*W-1:0] w_hold_flat;
    logic              w_all_held;
    logic              w_out_free;
    logic              w_pack;
    logic [PW-1:0]     r_out_tdata;
    logic              r_out_tvalid;

    assign w_all_held = &r_held;
    assign w_out_free = !r_out_tvalid | lii_out_tready;
    assign w_pack     = w_all_held & w_out_free;

    generate
        for (gi = 0; gi < NOUT; gi++) begin : g_out_lane
            logic [W-1:0] r_hold;

            // A lane may refill in the very cycle its word is packed away.
            assign k_out_tready[gi]        = !r_held[gi] | w_pack;
            assign w_capture[gi]           = k_out_tvalid[gi] & k_out_tready[gi];
            assign w_hold_flat[gi*W +: W]  = r_hold;

            always_ff @(posedge aclk or negedge arstn) begin
                if (!arstn) begin
                    r_hold      <= '0;
                    r_held[gi]  <= 1'b0;
                end else if (w_capture[gi]) begin
                    r_hold      <= k_out_tdata[gi*W +: W];
                    r_held[gi]  <= 1'b1;
                end else if (w_pack) begin
                    r_held[gi]  <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_out_tdata  <= '0;
            r_out_tvalid <= 1'b0;
        end else if (w_pack) begin
            r_out_tdata  <= PW'(w_hold_flat);
            r_out_tvalid <= 1'b1;
        end else if (lii_out_tready) begin
            r_out_tvalid <= 1'b0;
        end
    end

    assign lii_out_tdata  = r_out_tdata;
    assign lii_out_tvalid = r_out_tvalid;
    assign lii_out_src    = MY_ID;
    assign lii_out_dst    = DST_ID;

    // Stall the kernel only when every lane holds a word and the output beat cannot leave.
    assign ce = !(w_all_held & r_out_tvalid & !lii_out_tready);

endmodule

// File: tb/tb_lii_kernel_wrapper.sv
// Self-checking bench for lii_kernel_wrapper: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the lane FIFOs and output packer.
module tb_lii_kernel_wrapper;

    localparam int         NIN    = 3;
    localparam int         NOUT   = 2;
    localparam int         W      = 8;
    localparam int         PW     = 64;
    localparam int         DEPTH  = 4;
    localparam logic [7:0] MY_ID  = 8'h05;
    localparam logic [7:0] DST_ID = 8'hA7;
    localparam logic [7:0] BAD_ID = 8'h06;

    logic              aclk;
    logic              arstn;
    logic [PW-1:0]     lii_in_tdata;
    logic              lii_in_tvalid;
    logic              lii_in_tready;
    logic [7:0]        lii_in_src;
    logic [7:0]        lii_in_dst;
    logic [PW-1:0]     lii_out_tdata;
    logic              lii_out_tvalid;
    logic              lii_out_tready;
    logic [7:0]        lii_out_src;
    logic [7:0]        lii_out_dst;
    logic [NIN*W-1:0]  k_in_tdata;
    logic [NIN-1:0]    k_in_tvalid;
    logic [NIN-1:0]    k_in_tready;
    logic [NOUT*W-1:0] k_out_tdata;
    logic [NOUT-1:0]   k_out_tvalid;
    logic [NOUT-1:0]   k_out_tready;
    logic              ce;
    logic [15:0]       drop_cnt;

    lii_kernel_wrapper #(
        .NIN(NIN), .NOUT(NOUT), .W(W), .PW(PW), .DEPTH(DEPTH), .MY_ID(MY_ID), .DST_ID(DST_ID)
    ) dut (
        .aclk(aclk), .arstn(arstn),
        .lii_in_tdata(lii_in_tdata), .lii_in_tvalid(lii_in_tvalid), .lii_in_tready(lii_in_tready),
        .lii_in_src(lii_in_src), .lii_in_dst(lii_in_dst),
        .lii_out_tdata(lii_out_tdata), .lii_out_tvalid(lii_out_tvalid), .lii_out_tready(lii_out_tready),
        .lii_out_src(lii_out_src), .lii_out_dst(lii_out_dst),
        .k_in_tdata(k_in_tdata), .k_in_tvalid(k_in_tvalid), .k_in_tready(k_in_tready),
        .k_out_tdata(k_out_tdata), .k_out_tvalid(k_out_tvalid), .k_out_tready(k_out_tready),
        .ce(ce), .drop_cnt(drop_cnt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Reference model: per-lane FIFO contents, per-lane words awaiting packing, the beat on the bus.
    logic [W-1:0]  m_in_q  [NIN][$];
    logic [W-1:0]  m_out_q [NOUT][$];
    logic          m_bus_valid;
    logic [PW-1:0] m_bus_data;
    int            m_drop;
    int            n_checks;
    int            n_pass;

    function automatic bit any_in_pending();
        for (int i = 0; i < NIN; i++) if (m_in_q[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NIN; i++) m_in_q[i].delete();
        for (int j = 0; j < NOUT; j++) m_out_q[j].delete();
        m_bus_valid = 1'b0;
        m_bus_data  = '0;
        m_drop      = 0;
    endtask

    task automatic drive_idle();
        lii_in_tvalid  = 1'b0;
        lii_in_tdata   = '0;
        lii_in_dst     = MY_ID;
        lii_in_src     = 8'h00;
        k_in_tready    = '0;
        k_out_tvalid   = '0;
        k_out_tdata    = '0;
        lii_out_tready = 1'b1;
    endtask

    // One clock cycle: drive at posedge+1, compare with the model at negedge, advance the model.
    task automatic step(input logic iv, input logic [PW-1:0] idata, input logic [7:0] idst,
                        input logic [NIN-1:0] kready, input logic [NOUT-1:0] okv,
                        input logic [NOUT*W-1:0] okd, input logic otr);
        logic            exp_tready;
        logic            all_h;
        logic            pack;
        logic            exp_ce;
        logic [NOUT-1:0] exp_kotr;
        lii_in_tvalid  = iv;
        lii_in_tdata   = idata;
        lii_in_dst     = idst;
        lii_in_src     = 8'($urandom);
        k_in_tready    = kready;
        k_out_tvalid   = okv;
        k_out_tdata    = okd;
        lii_out_tready = otr;
        @(negedge aclk);
        exp_tready = 1'b1;
        for (int i = 0; i < NIN; i++) if (m_in_q[i].size() >= DEPTH) exp_tready = 1'b0;
        n_checks++;
        if (lii_in_tready !== exp_tready)
            $display("FAIL lii_in_tready t=%0t got %b expected %b", $time, lii_in_tready, exp_tready);
        else n_pass++;
        for (int i = 0; i < NIN; i++) begin
            n_checks++;
            if (k_in_tvalid[i] !== (m_in_q[i].size() != 0))
                $display("FAIL k_in_tvalid[%0d] t=%0t got %b expected %b", i, $time, k_in_tvalid[i], m_in_q[i].size() != 0);
            else n_pass++;
            if (m_in_q[i].size() != 0) begin
                n_checks++;
                if (k_in_tdata[i*W +: W] !== m_in_q[i][0])
                    $display("FAIL k_in_tdata[%0d] t=%0t got %h expected %h", i, $time, k_in_tdata[i*W +: W], m_in_q[i][0]);
                else n_pass++;
            end
        end
        n_checks++;
        if (drop_cnt !== 16'(m_drop))
            $display("FAIL drop_cnt t=%0t got %h expected %h", $time, drop_cnt, 16'(m_drop));
        else n_pass++;
        all_h = 1'b1;
        for (int j = 0; j < NOUT; j++) if (m_out_q[j].size() == 0) all_h = 1'b0;
        pack   = all_h & (!m_bus_valid | otr);
        exp_ce = !(all_h & m_bus_valid & !otr);
        for (int j = 0; j < NOUT; j++) exp_kotr[j] = (m_out_q[j].size() == 0) | pack;
        n_checks++;
        if (k_out_tready !== exp_kotr)
            $display("FAIL k_out_tready t=%0t got %b expected %b", $time, k_out_tready, exp_kotr);
        else n_pass++;
        n_checks++;
        if (ce !== exp_ce) $display("FAIL ce t=%0t got %b expected %b", $time, ce, exp_ce);
        else n_pass++;
        n_checks++;
        if (lii_out_tvalid !== m_bus_valid)
            $display("FAIL lii_out_tvalid t=%0t got %b expected %b", $time, lii_out_tvalid, m_bus_valid);
        else n_pass++;
        n_checks++;
        if (lii_out_tdata !== m_bus_data)
            $display("FAIL lii_out_tdata t=%0t got %h expected %h", $time, lii_out_tdata, m_bus_data);
        else n_pass++;
        for (int i = 0; i < NIN; i++)
            if (kready[i] && m_in_q[i].size() != 0) void'(m_in_q[i].pop_front());
        if (iv && exp_tready) begin
            if (idst == MY_ID) begin
                for (int i = 0; i < NIN; i++) m_in_q[i].push_back(idata[i*W +: W]);
            end else if (m_drop < 65535) begin
                m_drop++;
            end
        end
        if (pack) begin
            m_bus_data = '0;
            for (int j = 0; j < NOUT; j++) m_bus_data[j*W +: W] = m_out_q[j].pop_front();
            m_bus_valid = 1'b1;
        end else if (otr) begin
            m_bus_valid = 1'b0;
        end
        for (int j = 0; j < NOUT; j++)
            if (okv[j] && exp_kotr[j]) m_out_q[j].push_back(okd[j*W +: W]);
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_step(input logic otr);
        step(1'b0, '0, MY_ID, '0, '0, '0, otr);
    endtask

    task automatic do_reset();
        drive_idle();
        arstn = 1'b0;
        model_clear();
        @(negedge aclk);
        arstn = 1'b1;
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        drive_idle();
        arstn = 1'b0;
        model_clear();
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        n_checks++; if (k_in_tvalid !== '0) $display("FAIL reset_k_in_tvalid got %b expected 0", k_in_tvalid); else n_pass++;
        n_checks++; if (lii_in_tready !== 1'b1) $display("FAIL reset_in_tready got %b expected 1", lii_in_tready); else n_pass++;
        n_checks++; if (k_out_tready !== '1) $display("FAIL reset_k_out_tready got %b expected 11", k_out_tready); else n_pass++;
        n_checks++; if (ce !== 1'b1) $display("FAIL reset_ce got %b expected 1", ce); else n_pass++;
        n_checks++; if (lii_out_tvalid !== 1'b0) $display("FAIL reset_out_tvalid got %b expected 0", lii_out_tvalid); else n_pass++;
        n_checks++; if (lii_out_tdata !== '0) $display("FAIL reset_out_tdata got %h expected 0", lii_out_tdata); else n_pass++;
        n_checks++; if (drop_cnt !== 16'h0) $display("FAIL reset_drop_cnt got %h expected 0", drop_cnt); else n_pass++;
        n_checks++; if (lii_out_src !== MY_ID) $display("FAIL out_src got %h expected %h", lii_out_src, MY_ID); else n_pass++;
        n_checks++; if (lii_out_dst !== DST_ID) $display("FAIL out_dst got %h expected %h", lii_out_dst, DST_ID); else n_pass++;
        arstn = 1'b1;
        @(posedge aclk);
        #1;
    endtask

    task automatic test_basic();
        logic [PW-1:0] d;
        d = {$urandom, $urandom};
        d[23:0] = 24'hCCBBAA;
        step(1'b1, d, MY_ID, 3'b111, '0, '0, 1'b1);
        n_checks++; if (k_in_tvalid !== 3'b111) $display("FAIL basic_valid got %b expected 111", k_in_tvalid); else n_pass++;
        n_checks++; if (k_in_tdata !== 24'hCCBBAA) $display("FAIL basic_data got %h expected ccbbaa", k_in_tdata); else n_pass++;
        step(1'b0, d, MY_ID, 3'b111, '0, '0, 1'b1);
        n_checks++; if (k_in_tvalid !== 3'b000) $display("FAIL basic_after_pop got %b expected 000", k_in_tvalid); else n_pass++;
        idle_step(1'b1);
    endtask

    task automatic test_fill();
        for (int b = 0; b < DEPTH; b++) step(1'b1, {$urandom, $urandom}, MY_ID, '0, '0, '0, 1'b1);
        n_checks++; if (lii_in_tready !== 1'b0) $display("FAIL fill_full got %b expected 0", lii_in_tready); else n_pass++;
        step(1'b1, {$urandom, $urandom}, MY_ID, 3'b000, '0, '0, 1'b1);
        step(1'b1, {$urandom, $urandom}, MY_ID, 3'b001, '0, '0, 1'b1);
        n_checks++; if (lii_in_tready !== 1'b0) $display("FAIL fill_lane0_pop got %b expected 0", lii_in_tready); else n_pass++;
        step(1'b1, {$urandom, $urandom}, MY_ID, 3'b000, '0, '0, 1'b1);
        step(1'b0, '0, MY_ID, 3'b110, '0, '0, 1'b1);
        n_checks++; if (lii_in_tready !== 1'b1) $display("FAIL fill_reopen got %b expected 1", lii_in_tready); else n_pass++;
        for (int c = 0; c < 40 && any_in_pending(); c++)
            step(1'b0, '0, MY_ID, NIN'($urandom), '0, '0, 1'b1);
        n_checks++; if (k_in_tvalid !== '0) $display("FAIL fill_drain got %b expected 000", k_in_tvalid); else n_pass++;
    endtask

    task automatic test_drop();
        for (int b = 0; b < 3; b++) step(1'b1, {$urandom, $urandom}, BAD_ID, '0, '0, '0, 1'b1);
        n_checks++; if (drop_cnt !== 16'd3) $display("FAIL drop_three got %h expected 0003", drop_cnt); else n_pass++;
        n_checks++; if (k_in_tvalid !== '0) $display("FAIL drop_no_push got %b expected 000", k_in_tvalid); else n_pass++;
        force dut.r_drop_cnt = 16'hFFFE;
        #1;
        release dut.r_drop_cnt;
        m_drop = 16'hFFFE;
        for (int b = 0; b < 3; b++) step(1'b1, {$urandom, $urandom}, BAD_ID, '0, '0, '0, 1'b1);
        n_checks++; if (drop_cnt !== 16'hFFFF) $display("FAIL drop_saturate got %h expected ffff", drop_cnt); else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] dst;
        for (int c = 0; c < 400; c++) begin
            dst = ($urandom_range(7) == 0) ? BAD_ID : MY_ID;
            step(1'($urandom), {$urandom, $urandom}, dst, NIN'($urandom),
                 NOUT'($urandom), (NOUT*W)'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_output_pack();
        step(1'b0, '0, MY_ID, '0, 2'b01, 16'h0011, 1'b1);
        idle_step(1'b1);
        idle_step(1'b1);
        step(1'b0, '0, MY_ID, '0, 2'b10, 16'h2200, 1'b1);
        n_checks++; if (lii_out_tvalid !== 1'b0) $display("FAIL pack_early got %b expected 0", lii_out_tvalid); else n_pass++;
        idle_step(1'b1);
        n_checks++; if (lii_out_tvalid !== 1'b1) $display("FAIL pack_valid got %b expected 1", lii_out_tvalid); else n_pass++;
        n_checks++; if (lii_out_tdata !== 64'h2211) $display("FAIL pack_data got %h expected 2211", lii_out_tdata); else n_pass++;
        idle_step(1'b1);
        n_checks++; if (lii_out_tvalid !== 1'b0) $display("FAIL pack_consumed got %b expected 0", lii_out_tvalid); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [NOUT*W-1:0] first;
        logic [NOUT*W-1:0] second;
        first  = (NOUT*W)'($urandom);
        second = (NOUT*W)'($urandom);
        step(1'b0, '0, MY_ID, '0, 2'b11, first, 1'b0);
        idle_step(1'b0);
        step(1'b0, '0, MY_ID, '0, 2'b11, second, 1'b0);
        n_checks++; if (ce !== 1'b0) $display("FAIL bp_ce got %b expected 0", ce); else n_pass++;
        n_checks++; if (k_out_tready !== 2'b00) $display("FAIL bp_kready got %b expected 00", k_out_tready); else n_pass++;
        for (int c = 0; c < 3; c++) step(1'b0, '0, MY_ID, '0, 2'b11, (NOUT*W)'($urandom), 1'b0);
        n_checks++; if (lii_out_tdata !== PW'(first)) $display("FAIL bp_stable got %h expected %h", lii_out_tdata, PW'(first)); else n_pass++;
        idle_step(1'b1);
        n_checks++; if (lii_out_tvalid !== 1'b1) $display("FAIL bp_next_valid got %b expected 1", lii_out_tvalid); else n_pass++;
        n_checks++; if (lii_out_tdata !== PW'(second)) $display("FAIL bp_next_data got %h expected %h", lii_out_tdata, PW'(second)); else n_pass++;
        idle_step(1'b1);
    endtask

    task automatic test_reset_mid();
        step(1'b1, {$urandom, $urandom}, BAD_ID, '0, '0, '0, 1'b0);
        step(1'b1, {$urandom, $urandom}, MY_ID, '0, 2'b11, (NOUT*W)'($urandom), 1'b0);
        step(1'b1, {$urandom, $urandom}, MY_ID, '0, 2'b11, (NOUT*W)'($urandom), 1'b0);
        #2;
        arstn = 1'b0;
        #1;
        n_checks++; if (k_in_tvalid !== '0) $display("FAIL rmid_k_in_tvalid got %b expected 000", k_in_tvalid); else n_pass++;
        n_checks++; if (lii_out_tvalid !== 1'b0) $display("FAIL rmid_out_tvalid got %b expected 0", lii_out_tvalid); else n_pass++;
        n_checks++; if (drop_cnt !== 16'h0) $display("FAIL rmid_drop_cnt got %h expected 0", drop_cnt); else n_pass++;
        n_checks++; if (lii_in_tready !== 1'b1) $display("FAIL rmid_in_tready got %b expected 1", lii_in_tready); else n_pass++;
        n_checks++; if (k_out_tready !== '1) $display("FAIL rmid_k_out_tready got %b expected 11", k_out_tready); else n_pass++;
        model_clear();
        drive_idle();
        @(negedge aclk);
        arstn = 1'b1;
        @(posedge aclk);
        #1;
        idle_step(1'b1);
        idle_step(1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_basic();
        test_fill();
        test_drop();
        test_random();
        do_reset();
        test_output_pack();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
